// File: rtl/mgt_pkg.sv
// rtl/mgt_pkg.sv - shared MGT startup state encoding and 40 MHz timing defaults
package mgt_pkg;

  // Startup sequencer state encoding, also used by monitoring and the register map
  localparam logic [2:0] ST_PLL_RST        = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK      = 3'd1;
  localparam logic [2:0] ST_GTX_RST        = 3'd2;
  localparam logic [2:0] ST_WAIT_RESETDONE = 3'd3;
  localparam logic [2:0] ST_SETTLE         = 3'd4;
  localparam logic [2:0] ST_DONE           = 3'd5;
  localparam logic [2:0] ST_FAILED         = 3'd6;

  // Default timing at 40 MHz (LOCK/DONE timeouts are 1 ms, settle is 10 us)
  localparam int DEF_PLL_RESET_CYCLES = 16;
  localparam int DEF_GTX_RESET_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT     = 40000;
  localparam int DEF_DONE_TIMEOUT     = 40000;
  localparam int DEF_SETTLE_CYCLES    = 400;
  localparam int DEF_MAX_RETRIES      = 7;
  localparam int DEF_CNT_W            = 16;

  // Eight-bit increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous active-low reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [WIDTH-1:0] meta_q;
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give a metastability settling cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mgt_startup_fsm.sv
// rtl/mgt_startup_fsm.sv - TX MGT quad power-up / recovery sequencer
module mgt_startup_fsm
  import mgt_pkg::*;
#(
  parameter int PLL_RESET_CYCLES = DEF_PLL_RESET_CYCLES,
  parameter int GTX_RESET_CYCLES = DEF_GTX_RESET_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int DONE_TIMEOUT     = DEF_DONE_TIMEOUT,
  parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       clock_40,
  input  logic       reset_i,
  input  logic       restart_i,
  input  logic       pll_lock_i,
  input  logic       tx_resetdone_i,
  output logic       pll_reset_o,
  output logic       gtx_reset_o,
  output logic       mgt_startup_done_o,
  output logic       failed_o,
  output logic [7:0] retry_cnt_o,
  output logic [2:0] state_o
);

  // Terminal counts: each timed state exits when the counter reaches these
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GTX_LAST    = CNT_W'(GTX_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST   = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       sync_s;
  logic             lock_s;
  logic             rdone_s;
  logic             restart_q;
  logic             restart_edge;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             attempt_fail;
  logic             counting;

  logic             pll_reset_q;
  logic             gtx_reset_q;
  logic             done_q;
  logic             failed_q;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk_i  (clock_40),
    .rst_ni (reset_i),
    .d_i    ({pll_lock_i, tx_resetdone_i}),
    .q_o    (sync_s)
  );

  assign lock_s  = sync_s[1];
  assign rdone_s = sync_s[0];

  // Delay restart by one flop so only its rising edge restarts the sequence
  always_ff @(posedge clock_40 or negedge reset_i) begin
    if (!reset_i) restart_q <= 1'b0;
    else          restart_q <= restart_i;
  end

  assign restart_edge = restart_i & ~restart_q;

  // Next-state decision; restart beats timeout, timeout beats success
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    if (restart_edge) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (cnt_q == LOCK_LAST) attempt_fail = 1'b1;
          else if (lock_s)        state_d = ST_GTX_RST;
        end
        ST_GTX_RST: begin
          if (cnt_q == GTX_LAST) state_d = ST_WAIT_RESETDONE;
        end
        ST_WAIT_RESETDONE: begin
          if ((cnt_q == DONE_LAST) || !lock_s) attempt_fail = 1'b1;
          else if (rdone_s)                    state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!(lock_s && rdone_s))     attempt_fail = 1'b1;
          else if (cnt_q == SETTLE_LAST) state_d = ST_DONE;
        end
        ST_DONE: begin
          // Link loss after startup is a fresh start, not a failed attempt
          if (!(lock_s && rdone_s)) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
      if (attempt_fail) begin
        retry_d = sat_inc8(retry_q);
        state_d = (int'(retry_q) == MAX_RETRIES) ? ST_FAILED : ST_PLL_RST;
      end
    end
  end

  assign counting = (state_q != ST_DONE) && (state_q != ST_FAILED);

  // Shared cycle counter: cleared on any state change or restart, else counts
  always_comb begin
    cnt_d = cnt_q;
    if (restart_edge || (state_d != state_q)) cnt_d = '0;
    else if (counting)                        cnt_d = cnt_q + CNT_W'(1);
  end

  // State, counter, retry count and outputs, all registered off the next state
  always_ff @(posedge clock_40 or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      gtx_reset_q <= 1'b1;
      done_q      <= 1'b0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAILED);
      gtx_reset_q <= !((state_d == ST_WAIT_RESETDONE) || (state_d == ST_SETTLE) ||
                       (state_d == ST_DONE));
      done_q      <= (state_d == ST_DONE);
      failed_q    <= (state_d == ST_FAILED);
    end
  end

  assign pll_reset_o        = pll_reset_q;
  assign gtx_reset_o        = gtx_reset_q;
  assign mgt_startup_done_o = done_q;
  assign failed_o           = failed_q;
  assign retry_cnt_o        = retry_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_mgt_startup_fsm.sv
// tb/tb_mgt_startup_fsm.sv - self-checking bench for mgt_startup_fsm
module tb_mgt_startup_fsm;

  localparam int P  = 4;
  localparam int G  = 3;
  localparam int LT = 20;
  localparam int DT = 20;
  localparam int S  = 5;
  localparam int MR = 2;

  localparam int PH_PLL    = 0;
  localparam int PH_LOCK   = 1;
  localparam int PH_GTX    = 2;
  localparam int PH_RDONE  = 3;
  localparam int PH_SETTLE = 4;
  localparam int PH_DONE   = 5;
  localparam int PH_FAIL   = 6;

  logic       clock_40       = 1'b0;
  logic       reset_i        = 1'b0;
  logic       restart_i      = 1'b0;
  logic       pll_lock_i     = 1'b0;
  logic       tx_resetdone_i = 1'b0;
  logic       pll_reset_o;
  logic       gtx_reset_o;
  logic       mgt_startup_done_o;
  logic       failed_o;
  logic [7:0] retry_cnt_o;
  logic [2:0] state_o;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: phase plus the cycle it was entered
  int m_phase = PH_PLL;
  int m_cyc   = 0;
  int m_enter = 0;
  int m_retry = 0;
  bit ls1 = 0, ls2 = 0, rs1 = 0, rs2 = 0, rst_prev = 0;

  always #5 clock_40 = ~clock_40;

  mgt_startup_fsm #(
    .PLL_RESET_CYCLES (P),
    .GTX_RESET_CYCLES (G),
    .LOCK_TIMEOUT     (LT),
    .DONE_TIMEOUT     (DT),
    .SETTLE_CYCLES    (S),
    .MAX_RETRIES      (MR),
    .CNT_W            (16)
  ) dut (
    .clock_40           (clock_40),
    .reset_i            (reset_i),
    .restart_i          (restart_i),
    .pll_lock_i         (pll_lock_i),
    .tx_resetdone_i     (tx_resetdone_i),
    .pll_reset_o        (pll_reset_o),
    .gtx_reset_o        (gtx_reset_o),
    .mgt_startup_done_o (mgt_startup_done_o),
    .failed_o           (failed_o),
    .retry_cnt_o        (retry_cnt_o),
    .state_o            (state_o)
  );

  task automatic model_step();
    bit lock_ok, rdone_ok, edge_seen, fail_attempt;
    int el, nxt;
    lock_ok      = ls2;
    rdone_ok     = rs2;
    edge_seen    = restart_i && !rst_prev;
    el           = m_cyc - m_enter;
    nxt          = m_phase;
    fail_attempt = 0;
    if (edge_seen) begin
      nxt     = PH_PLL;
      m_retry = 0;
    end else begin
      if (m_phase == PH_PLL && el == P - 1) nxt = PH_LOCK;
      if (m_phase == PH_LOCK) begin
        if (el >= LT - 1) fail_attempt = 1;
        else if (lock_ok) nxt = PH_GTX;
      end
      if (m_phase == PH_GTX && el == G - 1) nxt = PH_RDONE;
      if (m_phase == PH_RDONE) begin
        if (el >= DT - 1 || !lock_ok) fail_attempt = 1;
        else if (rdone_ok)            nxt = PH_SETTLE;
      end
      if (m_phase == PH_SETTLE) begin
        if (!(lock_ok && rdone_ok)) fail_attempt = 1;
        else if (el == S - 1)       nxt = PH_DONE;
      end
      if (m_phase == PH_DONE && !(lock_ok && rdone_ok)) begin
        nxt     = PH_PLL;
        m_retry = 0;
      end
      if (fail_attempt) begin
        nxt     = (m_retry == MR) ? PH_FAIL : PH_PLL;
        m_retry = (m_retry >= 255) ? 255 : m_retry + 1;
      end
    end
    m_cyc = m_cyc + 1;
    if (nxt != m_phase || edge_seen) m_enter = m_cyc;
    m_phase  = nxt;
    ls2      = ls1;
    ls1      = pll_lock_i;
    rs2      = rs1;
    rs1      = tx_resetdone_i;
    rst_prev = restart_i;
  endtask

  // Model advances on each clock edge and resets with reset_i
  initial begin
    forever begin
      @(posedge clock_40 or negedge reset_i);
      if (!reset_i) begin
        m_phase = PH_PLL; m_cyc = 0; m_enter = 0; m_retry = 0;
        ls1 = 0; ls2 = 0; rs1 = 0; rs2 = 0; rst_prev = 0;
      end else begin
        model_step();
      end
    end
  end

  // Every cycle, compare all outputs against the model on the falling edge
  initial begin
    logic [14:0] act, exp_v;
    bit e_pll, e_gtx, e_done, e_fail;
    forever begin
      @(negedge clock_40);
      e_pll  = (m_phase == PH_PLL) || (m_phase == PH_FAIL);
      e_gtx  = (m_phase <= PH_GTX) || (m_phase == PH_FAIL);
      e_done = (m_phase == PH_DONE);
      e_fail = (m_phase == PH_FAIL);
      exp_v  = {e_pll, e_gtx, e_done, e_fail, 8'(m_retry), 3'(m_phase)};
      act    = {pll_reset_o, gtx_reset_o, mgt_startup_done_o, failed_o, retry_cnt_o, state_o};
      compared++;
      if (act !== exp_v) begin
        mismatched++;
        $display("FAIL cycle_model t=%0t actual pll/gtx/done/fail/retry/state=%b/%b/%b/%b/%0d/%0d required %b/%b/%b/%b/%0d/%0d",
                 $time, act[14], act[13], act[12], act[11], act[10:3], act[2:0],
                 exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:3], exp_v[2:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_40);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_state(input int code, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (int'(state_o) == code) begin
        found = 1;
        break;
      end
      tick(1);
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL wait_state: actual %0d required %0d within %0d cycles", state_o, code, budget);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll"}, pll_reset_o, 1);
    chk({tag, "_gtx"}, gtx_reset_o, 1);
    chk({tag, "_done"}, mgt_startup_done_o, 0);
    chk({tag, "_failed"}, failed_o, 0);
    chk({tag, "_retry"}, retry_cnt_o, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_reset_vals("rst");
    reset_i = 1'b1;

    // 1: nominal bring-up
    tick(3);
    chk("t1_pll_hi_c3", pll_reset_o, 1);
    tick(1);
    chk("t1_pll_low_c4", pll_reset_o, 0);
    chk("t1_wait_lock", state_o, PH_LOCK);
    tick(2);
    pll_lock_i = 1'b1;
    wait_state(PH_GTX, 20);
    chk("t1_gtx_hi_enter", gtx_reset_o, 1);
    tick(2);
    chk("t1_gtx_hi_c2", gtx_reset_o, 1);
    tick(1);
    chk("t1_gtx_low_c3", gtx_reset_o, 0);
    chk("t1_wait_rdone", state_o, PH_RDONE);
    tick(4);
    tx_resetdone_i = 1'b1;
    wait_state(PH_SETTLE, 20);
    tick(4);
    chk("t1_settle_c4", state_o, PH_SETTLE);
    chk("t1_done_low_c4", mgt_startup_done_o, 0);
    tick(1);
    chk("t1_done_hi_c5", mgt_startup_done_o, 1);
    chk("t1_retry", retry_cnt_o, 0);

    // 3: lock loss while done
    pll_lock_i = 1'b0;
    tick(2);
    chk("t3_done_c2", mgt_startup_done_o, 1);
    tick(1);
    chk("t3_done_c3", mgt_startup_done_o, 0);
    chk("t3_state", state_o, PH_PLL);
    chk("t3_retry", retry_cnt_o, 0);
    tick(6);
    pll_lock_i = 1'b1;
    wait_state(PH_DONE, 80);
    chk("t3_redone", mgt_startup_done_o, 1);
    chk("t3_retry_end", retry_cnt_o, 0);

    // 4: resetdone glitch at settle count 2
    tx_resetdone_i = 1'b0;
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    chk("t4_restart_state", state_o, PH_PLL);
    chk("t4_restart_done", mgt_startup_done_o, 0);
    wait_state(PH_RDONE, 40);
    tx_resetdone_i = 1'b1;
    wait_state(PH_SETTLE, 10);
    tx_resetdone_i = 1'b0;
    tick(1);
    tx_resetdone_i = 1'b1;
    tick(2);
    chk("t4_state", state_o, PH_PLL);
    chk("t4_retry", retry_cnt_o, 1);
    chk("t4_done", mgt_startup_done_o, 0);
    wait_state(PH_DONE, 60);
    chk("t4_retry_kept", retry_cnt_o, 1);

    // 2: lock never arrives, retries exhausted
    pll_lock_i = 1'b0;
    tx_resetdone_i = 1'b0;
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    chk("t2_retry0", retry_cnt_o, 0);
    wait_state(PH_LOCK, 10);
    tick(19);
    chk("t2_lock_c19", state_o, PH_LOCK);
    tick(1);
    chk("t2_timeout_state", state_o, PH_PLL);
    chk("t2_retry1", retry_cnt_o, 1);
    wait_state(PH_LOCK, 10);
    wait_state(PH_PLL, 30);
    chk("t2_retry2", retry_cnt_o, 2);
    wait_state(PH_FAIL, 40);
    chk("t2_retry3", retry_cnt_o, 3);
    chk("t2_failed", failed_o, 1);
    chk("t2_pll", pll_reset_o, 1);
    chk("t2_gtx", gtx_reset_o, 1);
    tick(5);
    chk("t2_stays", state_o, PH_FAIL);
    pll_lock_i = 1'b1;
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    chk("t2_clr_failed", failed_o, 0);
    chk("t2_clr_retry", retry_cnt_o, 0);
    chk("t2_clr_state", state_o, PH_PLL);

    // 6a: resetdone arrives in the timeout cycle; timeout wins
    wait_state(PH_RDONE, 40);
    tick(17);
    tx_resetdone_i = 1'b1;
    tick(2);
    chk("t6a_still_wait", state_o, PH_RDONE);
    tick(1);
    chk("t6a_state", state_o, PH_PLL);
    chk("t6a_retry", retry_cnt_o, 1);
    tx_resetdone_i = 1'b0;

    // 6b: restart edge coincident with a timeout
    wait_state(PH_RDONE, 40);
    tick(19);
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    chk("t6b_state", state_o, PH_PLL);
    chk("t6b_retry", retry_cnt_o, 0);

    // 5: asynchronous reset mid WAIT_RESETDONE
    wait_state(PH_RDONE, 40);
    tick(2);
    #1;
    reset_i = 1'b0;
    #1;
    chk_reset_vals("t5");
    tick(2);
    tx_resetdone_i = 1'b1;
    reset_i = 1'b1;
    tick(1);
    chk("t5_restart_state", state_o, PH_PLL);
    chk("t5_restart_pll", pll_reset_o, 1);
    wait_state(PH_DONE, 60);
    chk("t5_done", mgt_startup_done_o, 1);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
